// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared constants, state encoding and helpers for the program
//               memory loader (prog_loader / word_packer).
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // Host link carries one byte per transfer
    localparam int BYTE_W = 8;

    // Loader state encoding (explicit 3-bit width)
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LEN  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_CSUM = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_ERR  = 3'd5;

    // Number of host bytes that make up one instruction word
    function automatic int bytes_per_word(input int word_width);
        return word_width / BYTE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/word_packer.sv
`default_nettype none
// ============================================================================
// Module      : word_packer
// Description : Shifts accepted bytes MSB-first into an instruction word and
//               emits a one-cycle o_word_valid the cycle after the final byte
//               of a word is accepted. o_word holds until the next word.
// Revision    : 1.0 - initial release
// ============================================================================
module word_packer
    import prog_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 24
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_accept,
    input  logic [BYTE_W-1:0]     i_byte,
    output logic                  o_last,
    output logic                  o_word_valid,
    output logic [WORD_WIDTH-1:0] o_word
);

    localparam int c_BPW = bytes_per_word(WORD_WIDTH);
    localparam int c_CW  = (c_BPW > 1) ? $clog2(c_BPW) : 1;

    logic [c_CW-1:0]       r_cnt;
    logic [WORD_WIDTH-1:0] r_acc;
    logic [WORD_WIDTH-1:0] r_word;
    logic                  r_word_valid;
    logic [WORD_WIDTH-1:0] w_next_acc;
    logic                  w_last;

    // Next accumulator value: earlier bytes move toward the MSB end
    assign w_next_acc = (r_acc << BYTE_W) | WORD_WIDTH'(i_byte);
    assign w_last     = i_accept && (r_cnt == c_CW'(c_BPW - 1));

    // Byte counting, shifting and word capture on the final byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= w_last;
            if (i_clear) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (i_accept) begin
                r_acc <= w_next_acc;
                r_cnt <= w_last ? '0 : r_cnt + c_CW'(1);
                if (w_last) begin
                    r_word <= w_next_acc;
                end
            end
        end
    end

    assign o_last       = w_last;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Program-memory writer. Receives a length byte followed by
//               instruction bytes (MSB first) over a valid/ready byte link,
//               writes assembled words at incrementing addresses from 0 and
//               holds the core in reset while loading.
//               Optional checksum stage: define PROG_LOADER_CSUM_EN to expect
//               a trailing XOR-of-data-bytes checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 24,
    parameter int ADDR_BITS  = 8
)
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_BITS:0]    words_loaded
);

    localparam int c_LW = ADDR_BITS + 1;

    state_t                r_state;
    logic [c_LW-1:0]       r_len;
    logic [c_LW-1:0]       r_words_loaded;
    logic [ADDR_BITS-1:0]  r_mem_addr;
    logic                  r_cpu_rst;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]            r_csum;
`endif

    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_start_go;
    logic                  w_len_ok;
    logic                  w_word_last;
    logic                  w_final_word;
    logic                  w_word_valid;
    logic [WORD_WIDTH-1:0] w_word;

    // Handshake, start qualification and length validation
    assign w_ready      = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_xfer       = byte_valid && w_ready;
    assign w_start_go   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_len_ok     = (byte_in != 8'd0) && (32'(byte_in) <= (32'd1 << ADDR_BITS));
    assign w_final_word = (r_words_loaded + c_LW'(1)) == r_len;

    word_packer #(
        .WORD_WIDTH   (WORD_WIDTH)
    ) u_word_packer (
        .clk          (clk_in),
        .rst          (rst_in),
        .i_clear      (w_start_go),
        .i_accept     (w_xfer && (r_state == ST_DATA)),
        .i_byte       (byte_in),
        .o_last       (w_word_last),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Load sequencing, write addressing, status flags and checksum
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state        <= ST_IDLE;
            r_len          <= '0;
            r_words_loaded <= '0;
            r_mem_addr     <= '0;
            r_cpu_rst      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            r_csum         <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_start_go) begin
                        r_state        <= ST_LEN;
                        r_done         <= 1'b0;
                        r_error        <= 1'b0;
                        r_words_loaded <= '0;
                        r_cpu_rst      <= 1'b1;
                        r_busy         <= 1'b1;
`ifdef PROG_LOADER_CSUM_EN
                        r_csum         <= '0;
`endif
                    end
                end
                ST_LEN: begin
                    if (w_xfer) begin
                        if (w_len_ok) begin
                            r_len   <= c_LW'(byte_in);
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
`ifdef PROG_LOADER_CSUM_EN
                    if (w_xfer) begin
                        r_csum <= r_csum ^ byte_in;
                    end
`endif
                    if (w_word_last) begin
                        r_mem_addr     <= r_words_loaded[ADDR_BITS-1:0];
                        r_words_loaded <= r_words_loaded + c_LW'(1);
                        if (w_final_word) begin
`ifdef PROG_LOADER_CSUM_EN
                            r_state   <= ST_CSUM;
`else
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_cpu_rst <= 1'b0;
`endif
                        end
                    end
                end
`ifdef PROG_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (w_xfer) begin
                        r_busy <= 1'b0;
                        if (byte_in == r_csum) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready   = w_ready;
    assign mem_we       = w_word_valid;
    assign mem_addr     = r_mem_addr;
    assign mem_data     = w_word;
    assign cpu_rst      = r_cpu_rst;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire
